// File: rtl/ghost_regbank.sv
// Bank of NREG host registers with per-register strobes, a host/fabric RAM window,
// a fixed-latency host read pipeline and a saturating unmapped-access counter.
module ghost_regbank #(
    parameter int             AW        = 24,
    parameter int             DW        = 32,
    parameter int             GW        = 8,
    parameter int             NREG      = 4,
    parameter logic [GW-1:0]  RESET_VAL = 8'h42,
    parameter int             RW        = 4,
    parameter int             RD        = 8,
    parameter int             RAM_BASE  = 'h40,
    parameter int             RDELAY    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          bus_addr,
    input  logic [DW-1:0]          bus_wdata,
    input  logic                   bus_we,
    input  logic                   bus_re,
    output logic [DW-1:0]          bus_rdata,
    output logic                   bus_rvalid,
    output logic [NREG*GW-1:0]     reg_q,
    output logic [NREG-1:0]        reg_ws,
    output logic [NREG-1:0]        reg_rs,
    input  logic [$clog2(RD)-1:0]  loc_addr,
    output logic [RW-1:0]          loc_rdata,
    output logic [7:0]             err_cnt
);
    localparam int             AB         = $clog2(RD);
    localparam logic [AW-1:0]  RAM_BASE_A = AW'(RAM_BASE);

    logic [NREG-1:0]          reg_hit;
    logic                     ram_hit;
    logic                     unmapped;
    logic [AB-1:0]            ram_idx;
    logic [DW-1:0]            rd_data;
    logic [DW-1:0]            unused_wdata;

    logic [NREG*GW-1:0]       regs_q, regs_d;
    logic [NREG-1:0]          ws_q, ws_d;
    logic [NREG-1:0]          rs_q, rs_d;
    logic [7:0]               err_q, err_d;
    logic [RW-1:0]            loc_rdata_q, loc_rdata_d;
    logic [RDELAY-1:0]        pv_q, pv_d;
    logic [RDELAY-1:0][DW-1:0] pd_q, pd_d;
    logic [RDELAY:0]          v_chain;
    logic [RDELAY:0][DW-1:0]  d_chain;

    logic [RW-1:0]            ram_mem [RD];

    assign unused_wdata = bus_wdata;

    // The RAM window is aligned to RD, so its decode is a compare of the upper address bits.
    assign ram_hit  = (bus_addr[AW-1:AB] == RAM_BASE_A[AW-1:AB]);
    assign ram_idx  = bus_addr[AB-1:0];
    assign unmapped = ~(|reg_hit) & ~ram_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_hit
            assign reg_hit[gi] = (bus_addr == AW'(gi));
        end
    endgenerate

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (bus_we && reg_hit[i]) begin
                regs_d[i*GW +: GW] = bus_wdata[GW-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = DW'(ram_mem[ram_idx]);
        end
        for (int i = 0; i < NREG; i++) begin
            if (reg_hit[i]) begin
                rd_data = DW'(regs_q[i*GW +: GW]);
            end
        end
    end

    // Stage data only moves with a valid token, so the last stage holds its last read.
    always_comb begin
        v_chain = {pv_q, bus_re};
        d_chain = {pd_q, rd_data};
        pv_d    = '0;
        pd_d    = pd_q;
        for (int i = 0; i < RDELAY; i++) begin
            pv_d[i] = v_chain[i];
            if (v_chain[i]) begin
                pd_d[i] = d_chain[i];
            end
        end
    end

    always_comb begin
        ws_d        = bus_we ? reg_hit : '0;
        rs_d        = bus_re ? reg_hit : '0;
        err_d       = err_q;
        loc_rdata_d = ram_mem[loc_addr];
        if ((bus_we || bus_re) && unmapped && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= {NREG{RESET_VAL}};
            ws_q        <= '0;
            rs_q        <= '0;
            err_q       <= '0;
            loc_rdata_q <= '0;
            pv_q        <= '0;
            pd_q        <= '0;
        end else begin
            regs_q      <= regs_d;
            ws_q        <= ws_d;
            rs_q        <= rs_d;
            err_q       <= err_d;
            loc_rdata_q <= loc_rdata_d;
            pv_q        <= pv_d;
            pd_q        <= pd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus_we && ram_hit) begin
            ram_mem[ram_idx] <= bus_wdata[RW-1:0];
        end
    end

    assign reg_q      = regs_q;
    assign reg_ws     = ws_q;
    assign reg_rs     = rs_q;
    assign err_cnt    = err_q;
    assign loc_rdata  = loc_rdata_q;
    assign bus_rvalid = pv_q[RDELAY-1];
    assign bus_rdata  = pd_q[RDELAY-1];
endmodule

// File: tb/tb_ghost_regbank.sv
// Drives a 1-cycle and a 3-cycle read-latency instance with the same host traffic
// and checks both against an address-map model every cycle.
module tb_ghost_regbank;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we, bus_re;
    logic [2:0]  loc_addr;

    logic [31:0] rdata1, rdata3, regq1, regq3;
    logic        rvalid1, rvalid3;
    logic [3:0]  ws1, ws3, rs1, rs3, locd1, locd3;
    logic [7:0]  err1, err3;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ghost_regbank #(.RDELAY(1)) u_d1 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(rdata1), .bus_rvalid(rvalid1),
        .reg_q(regq1), .reg_ws(ws1), .reg_rs(rs1), .loc_addr(loc_addr),
        .loc_rdata(locd1), .err_cnt(err1)
    );

    ghost_regbank #(.RDELAY(3)) u_d3 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(rdata3), .bus_rvalid(rvalid3),
        .reg_q(regq3), .reg_ws(ws3), .reg_rs(rs3), .loc_addr(loc_addr),
        .loc_rdata(locd3), .err_cnt(err3)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [7:0]  m_reg [4];
    logic [3:0]  m_ram [8];
    bit          m_known [8];
    int          m_err;
    rd_t         q1[$];
    rd_t         q3[$];
    logic [31:0] last1, last3;
    logic [3:0]  ws_e, rs_e, loc_e;
    bit          loc_known;

    always @(posedge clk or posedge rst) begin
        int          a;
        logic [31:0] d;
        bit          is_reg, is_ram;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 8'h42;
            m_err = 0;
            q1.delete();
            q3.delete();
            last1 = 0;
            last3 = 0;
            ws_e = 0;
            rs_e = 0;
            loc_e = 0;
            loc_known = 1;
        end else begin
            cyc++;
            a = int'(bus_addr);
            is_reg = (a < 4);
            is_ram = (a >= 'h40) && (a < 'h48);
            loc_e = m_ram[loc_addr];
            loc_known = m_known[loc_addr];
            ws_e = 0;
            rs_e = 0;
            if (bus_re) begin
                d = 0;
                if (is_reg) d = {24'h0, m_reg[a]};
                else if (is_ram) d = {28'h0, m_ram[a - 'h40]};
                q1.push_back('{cyc, d});
                q3.push_back('{cyc + 2, d});
                if (is_reg) rs_e[a] = 1'b1;
            end
            if ((bus_we || bus_re) && !is_reg && !is_ram && m_err < 255) m_err++;
            if (bus_we && is_reg) begin
                m_reg[a] = bus_wdata[7:0];
                ws_e[a] = 1'b1;
            end
            if (bus_we && is_ram) begin
                m_ram[a - 'h40] = bus_wdata[3:0];
                m_known[a - 'h40] = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] exp_regs;
        if (!rst) begin
            exp_regs = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
            chk("reg_q_d1", regq1, exp_regs);
            chk("reg_q_d3", regq3, exp_regs);
            chk("reg_ws", {28'h0, ws1}, {28'h0, ws_e});
            chk("reg_rs", {28'h0, rs1}, {28'h0, rs_e});
            chk("reg_rs_d3", {28'h0, rs3}, {28'h0, rs_e});
            chk("err_cnt", {24'h0, err1}, m_err);
            chk("err_cnt_d3", {24'h0, err3}, m_err);
            if (loc_known) chk("loc_rdata", {28'h0, locd1}, {28'h0, loc_e});
            if (q1.size() > 0 && q1[0].due == cyc) begin
                chk("rvalid_d1", {31'h0, rvalid1}, 1);
                chk("rdata_d1", rdata1, q1[0].data);
                last1 = q1[0].data;
                void'(q1.pop_front());
            end else begin
                chk("rvalid_d1", {31'h0, rvalid1}, 0);
                chk("rdata_hold_d1", rdata1, last1);
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                chk("rvalid_d3", {31'h0, rvalid3}, 1);
                chk("rdata_d3", rdata3, q3[0].data);
                last3 = q3[0].data;
                void'(q3.pop_front());
            end else begin
                chk("rvalid_d3", {31'h0, rvalid3}, 0);
                chk("rdata_hold_d3", rdata3, last3);
            end
        end
    end

    // One host transaction: inputs held across exactly one sampling edge.
    task automatic bus(input logic we, input logic re, input logic [23:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #2;
        bus_we = we;
        bus_re = re;
        bus_addr = addr;
        bus_wdata = wd;
        $display("txn we=%0b re=%0b addr=%h wdata=%h", we, re, addr, wd);
        @(posedge clk);
        #2;
        bus_we = 0;
        bus_re = 0;
    endtask

    initial begin
        int pulses;
        rst = 1;
        bus_we = 0;
        bus_re = 0;
        bus_addr = 0;
        bus_wdata = 0;
        loc_addr = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_reg_q", regq1, 32'h42424242);
        chk("rst_err_cnt", {24'h0, err1}, 0);
        chk("rst_rvalid", {31'h0, rvalid1}, 0);

        bus(0, 1, 24'h2, 0);
        @(negedge clk);
        chk("rd2_rvalid", {31'h0, rvalid1}, 1);
        chk("rd2_rdata", rdata1, 32'h00000042);
        chk("rd2_reg_rs", {28'h0, rs1}, 32'h4);

        bus(1, 0, 24'h1, 32'hFFFF_A55A);
        @(negedge clk);
        chk("wr1_reg_q", {24'h0, regq1[15:8]}, 32'h5A);
        chk("wr1_reg_ws", {28'h0, ws1}, 32'h2);
        bus(0, 1, 24'h1, 0);
        @(negedge clk);
        chk("rd1_rdata", rdata1, 32'h0000005A);

        bus(1, 0, 24'h40, 32'h1);
        bus(1, 0, 24'h41, 32'h2);
        bus(1, 0, 24'h42, 32'h3);
        bus(1, 0, 24'h43, 32'hFFFF_FFF9);
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            bus_re = 1;
            bus_addr = 24'h40 + 24'(i);
            $display("txn we=0 re=1 addr=%h (burst)", bus_addr);
            @(posedge clk);
            #2;
        end
        bus_re = 0;
        repeat (3) @(negedge clk);
        chk("burst_last_rvalid_d3", {31'h0, rvalid3}, 1);
        chk("burst_last_rdata_d3", rdata3, 32'h9);

        loc_addr = 3;
        @(posedge clk);
        @(negedge clk);
        chk("loc_rdata_3", {28'h0, locd1}, 32'h9);

        bus(1, 1, 24'h0, 32'h11);
        @(negedge clk);
        chk("rbw_rdata", rdata1, 32'h42);
        chk("rbw_reg_q", {24'h0, regq1[7:0]}, 32'h11);
        chk("rbw_ws0", {31'h0, ws1[0]}, 1);
        chk("rbw_rs0", {31'h0, rs1[0]}, 1);

        for (int i = 0; i < 300; i++) bus(0, 1, 24'h20, 0);
        @(negedge clk);
        chk("err_sat", {24'h0, err1}, 255);
        bus(1, 0, 24'h20, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("unmapped_wr_reg_q", regq1, 32'h4242_5A11);

        bus(0, 1, 24'h43, 0);
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #2 rst = 0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(rvalid3) + int'(rvalid1);
        end
        chk("rst_midread_pulses", pulses, 0);
        chk("rst_midread_reg_q", regq3, 32'h42424242);
        chk("rst_midread_err", {24'h0, err3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ghost_regbank.md
Name: ghost_regbank

Overview:
- Parametrised successor to the single-register ghostbus test submodule: a bank of NREG host-accessible registers, each with its own write strobe and read strobe, plus a host-accessible RAM region with configurable read latency.
- Also holds a saturating counter of unmapped-access errors.
- Sits under a ghostbus-decoded parent and exposes register values, strobes and a local RAM read port to fabric logic.

Parameters:
- AW, 24, host address width.
- DW, 32, host data width.
- GW, 8, register width (GW <= DW).
- NREG, 4, number of registers, at relative addresses 0..NREG-1.
- RESET_VAL, 8'h42, reset value of every register (GW bits).
- RW, 4, RAM word width (RW <= DW).
- RD, 8, RAM depth (power of 2).
- RAM_BASE, 'h40, RAM relative base address; aligned to RD, and RAM_BASE >= NREG.
- RDELAY, 1, host read latency in cycles (1..4).

Ports:
- clk  in  1  bus and fabric clock.
- rst  in  1  asynchronous reset, active-high.
- bus_addr  in  AW  relative host address.
- bus_wdata  in  DW  host write data.
- bus_we  in  1  host write enable, single-cycle qualifier.
- bus_re  in  1  host read enable, single-cycle qualifier.
- bus_rdata  out  DW  host read data, valid when bus_rvalid=1.
- bus_rvalid  out  1  read-data valid pulse.
- reg_q  out  NREG*GW  register values; register i at bits [i*GW +: GW].
- reg_ws  out  NREG  per-register write strobe.
- reg_rs  out  NREG  per-register read strobe.
- loc_addr  in  clog2(RD)  fabric RAM read address.
- loc_rdata  out  RW  fabric RAM read data, 1-cycle latency.
- err_cnt  out  8  saturating count of unmapped accesses.

Behaviour:
- Reset (async, rst=1):
  - every register = RESET_VAL; reg_ws = reg_rs = 0.
  - bus_rvalid = 0, bus_rdata = 0, read pipeline flushed.
  - err_cnt = 0, loc_rdata = 0.
  - RAM contents are not reset.
- Address map:
  - Addresses 0..NREG-1 are registers.
  - Addresses RAM_BASE..RAM_BASE+RD-1 are RAM.
  - Every other address is unmapped.
  - Full AW-bit compare; no aliasing.
- Write (bus_we=1 at edge k):
  - Register: stores bus_wdata[GW-1:0]; new value is visible on reg_q after edge k; reg_ws[i]=1 for exactly the cycle after edge k.
  - RAM: stores bus_wdata[RW-1:0].
  - Unmapped: no state change except err_cnt.
- Read (bus_re=1 at edge k):
  - Data is sampled at edge k. bus_rvalid=1 and bus_rdata are presented for exactly one cycle, in the cycle after edge k+RDELAY-1 (RDELAY=1 gives valid in the cycle after edge k).
  - Register data and RAM data are zero-extended to DW. Unmapped reads return 0 with rvalid still asserted.
  - reg_rs[i]=1 for the cycle after edge k, independent of RDELAY.
  - bus_rdata holds its last value when rvalid=0.
- Pipelining: a new read is accepted every cycle; N back-to-back reads produce N consecutive rvalid pulses in order.
- Simultaneous bus_we and bus_re, same address: read returns the pre-write value (read-before-write); both strobes fire.
- err_cnt: increments on each cycle with (bus_we|bus_re) at an unmapped address, counting once if both are set. Saturates at 255 and never wraps.
- Local RAM port: loc_rdata = ram[loc_addr] registered one cycle. If the host writes the same word in the same cycle, loc_rdata returns the old value.
- Reset asserted mid-read: the in-flight read is discarded and no rvalid follows reset deassertion.
- Implementation: no combinational path from bus inputs to bus outputs; all outputs registered.

Test Plan:
- Reset → reg_q = {4{8'h42}}, err_cnt=0, bus_rvalid=0. Then read addr 2 → rvalid 1 cycle later, rdata=32'h00000042, reg_rs=4'b0100 for one cycle.
- Write addr 1 data 32'hFFFF_A55A → reg_q[15:8]=8'h5A after the edge, reg_ws=4'b0010 for one cycle; read back gives 32'h0000005A.
- RDELAY=3: write RAM addr 'h43 data 'h9, then 4 back-to-back reads of 'h40..'h43 → 4 consecutive rvalid pulses starting 3 cycles after the first re, last rdata=32'h9. loc_addr=3 → loc_rdata=4'h9 one cycle later.
- Simultaneous we+re to addr 0 with data 8'h11, previous value 8'h42 → rdata=32'h42, reg_q[7:0]=8'h11, reg_ws[0]=reg_rs[0]=1.
- 300 reads to addr 'h20 → each returns 0 with rvalid, err_cnt stops at 255; a write to 'h20 leaves all registers unchanged.
- Issue a read with RDELAY=3, assert rst one cycle later and deassert it → no rvalid ever, registers back to 8'h42, err_cnt=0.
